mem_xbar_sp: RTL

- Parametrised N-host to single-port-SRAM arbiter for Ibex-class req/gnt/rvalid buses.
- Generalises the fixed 2-host (instr over data) SRAM hookup in FPGA tops:
  - configurable host count, data width and arbitration mode;
  - in-cycle grant;
  - explicit out-of-range error responses;
  - per-host response routing.
- Sits between ibex_top (plus optional DMA/debug hosts) and one ram_1p instance.

---
 rtl/mem_xbar_sp.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_xbar_sp.sv
// N-host to single-port SRAM arbiter with in-cycle grant, window decode and 1-cycle responses.
// Optional per-host grant counters: define MEM_XBAR_PERF_CNT_EN.
module mem_xbar_sp #(
  parameter int unsigned          NumHosts   = 2,
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          AddrWidth  = 32,
  parameter logic [AddrWidth-1:0] MemStart   = '0,
  parameter int unsigned          MemSize    = 65536,
  parameter int unsigned          RoundRobin = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumHosts-1:0]              host_req_i,
  input  logic [NumHosts-1:0]              host_we_i,
  input  logic [NumHosts*DataWidth/8-1:0]  host_be_i,
  input  logic [NumHosts*AddrWidth-1:0]    host_addr_i,
  input  logic [NumHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NumHosts-1:0]              host_gnt_o,
  output logic [NumHosts-1:0]              host_rvalid_o,
  output logic [NumHosts-1:0]              host_err_o,
  output logic [DataWidth-1:0]             host_rdata_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [DataWidth/8-1:0]           mem_be_o,
  output logic [AddrWidth-1:0]             mem_addr_o,
  output logic [DataWidth-1:0]             mem_wdata_o,
  input  logic [DataWidth-1:0]             mem_rdata_i,
  output logic [NumHosts*32-1:0]           perf_gnt_cnt_o
);

  localparam int unsigned          BeW     = DataWidth / 8;
  localparam int unsigned          IdxW    = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam logic [AddrWidth-1:0] MemMask = AddrWidth'(MemSize - 1);

  logic [IdxW-1:0]      r_ptr;
  logic                 r_rsp_vld;
  logic [IdxW-1:0]      r_rsp_idx;
  logic                 r_rsp_err;
  logic                 r_rsp_we;

  logic                 w_win_vld;
  logic [IdxW-1:0]      w_win_idx;
  logic [IdxW:0]        w_cand;
  logic [AddrWidth-1:0] w_addr;
  logic                 w_we;
  logic [BeW-1:0]       w_be;
  logic [DataWidth-1:0] w_wdata;
  logic                 w_in_range;

  // Candidate order is rotated by the pointer in round-robin mode; the first requester wins.
  // Grants are suppressed while reset is asserted so every output reads zero.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NumHosts; k++) begin
      if (RoundRobin != 0) begin
        w_cand = {1'b0, r_ptr} + (IdxW+1)'(k);
        if (w_cand >= (IdxW+1)'(NumHosts)) begin
          w_cand = w_cand - (IdxW+1)'(NumHosts);
        end
      end else begin
        w_cand = (IdxW+1)'(k);
      end
      if (!w_win_vld && rst_ni && host_req_i[w_cand[IdxW-1:0]]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand[IdxW-1:0];
      end
    end
  end

  assign w_addr     = host_addr_i[w_win_idx*AddrWidth +: AddrWidth];
  assign w_we       = host_we_i[w_win_idx];
  assign w_be       = host_be_i[w_win_idx*BeW +: BeW];
  assign w_wdata    = host_wdata_i[w_win_idx*DataWidth +: DataWidth];
  assign w_in_range = ((w_addr & ~MemMask) == MemStart);

  always_comb begin
    host_gnt_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_win_vld) begin
      host_gnt_o[w_win_idx] = 1'b1;
      if (w_in_range) begin
        mem_req_o   = 1'b1;
        mem_we_o    = w_we;
        mem_be_o    = w_be;
        mem_addr_o  = w_addr & MemMask;
        mem_wdata_o = w_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr     <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_idx <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_we  <= 1'b0;
    end else begin
      r_rsp_vld <= w_win_vld;
      if (w_win_vld) begin
        r_rsp_idx <= w_win_idx;
        r_rsp_err <= !w_in_range;
        r_rsp_we  <= w_we;
        r_ptr     <= (w_win_idx == IdxW'(NumHosts - 1)) ? '0 : w_win_idx + 1'b1;
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (r_rsp_vld) begin
      host_rvalid_o[r_rsp_idx] = 1'b1;
      host_err_o[r_rsp_idx]    = r_rsp_err;
      if (!r_rsp_err && !r_rsp_we) begin
        host_rdata_o = mem_rdata_i;
      end
    end
  end

`ifdef MEM_XBAR_PERF_CNT_EN
  logic [NumHosts-1:0][31:0] r_gnt_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NumHosts; i++) begin
        if (host_gnt_o[i] && (r_gnt_cnt[i] != '1)) begin
          r_gnt_cnt[i] <= r_gnt_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign perf_gnt_cnt_o = r_gnt_cnt;
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule
